// File: rtl/calc_sequencer.sv
// Front-end controller for the 8-bit accumulator calculator: conditions the
// Enter button, sequences the ALU through execute/commit and owns the accumulator.
module calc_sequencer #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enter_in,
    input  logic             clear_in,
    input  logic [WIDTH-1:0] num_in,
    input  logic [1:0]       op_in,
    output logic [WIDTH-1:0] acc_out,
    output logic             carry_out,
    output logic             zero_out,
    output logic             busy_out,
    output logic             done_out,
    output logic             overrun_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_EQ  = 2'b11;

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    state_t state;
    state_t next;

    logic             s1;
    logic             s2;
    logic             db;
    logic             db_d;
    logic [7:0]       cnt;
    logic             press;

    logic [WIDTH-1:0] opnd_r;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] result_r;
    logic             cy_r;

    logic [WIDTH-1:0] alu_res;
    logic             alu_cy;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    logic             load;
    logic             exec;
    logic             commit;
    logic             lost;

    // Two-flop synchroniser for the asynchronous button level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= enter_in;
            s2 <= s1;
        end
    end

    // Level only moves after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db  <= 1'b0;
            cnt <= 8'd0;
        end else if (s2 == db) begin
            cnt <= 8'd0;
        end else if (cnt == CNT_LAST) begin
            db  <= s2;
            cnt <= 8'd0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_d <= 1'b0;
        end else begin
            db_d <= db;
        end
    end

    assign press = db & ~db_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        if (clear_in) begin
            next = IDLE;
        end else begin
            case (state)
                IDLE:    if (press) next = EXEC;
                EXEC:    next = COMMIT;
                COMMIT:  next = IDLE;
                default: next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy_out = (state != IDLE);
        load     = (state == IDLE) & press & ~clear_in;
        exec     = (state == EXEC) & ~clear_in;
        commit   = (state == COMMIT) & ~clear_in;
        lost     = (state != IDLE) & press & ~clear_in;
    end

    assign sum  = {1'b0, acc_out} + {1'b0, opnd_r};
    assign diff = {1'b0, acc_out} - {1'b0, opnd_r};

    // The extra MSB of diff is the unsigned borrow
    always_comb begin
        alu_res = '0;
        alu_cy  = 1'b0;
        case (op_r)
            OP_ADD:  {alu_cy, alu_res} = sum;
            OP_SUB:  {alu_cy, alu_res} = diff;
            OP_OR:   alu_res = acc_out | opnd_r;
            OP_EQ:   alu_res = WIDTH'(acc_out == opnd_r);
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opnd_r <= '0;
            op_r   <= OP_ADD;
        end else if (load) begin
            opnd_r <= num_in;
            op_r   <= op_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_r <= '0;
            cy_r     <= 1'b0;
        end else if (exec) begin
            result_r <= alu_res;
            cy_r     <= alu_cy;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_out   <= '0;
            carry_out <= 1'b0;
            zero_out  <= 1'b1;
        end else if (clear_in) begin
            acc_out   <= '0;
            carry_out <= 1'b0;
            zero_out  <= 1'b1;
        end else if (commit) begin
            acc_out   <= result_r;
            carry_out <= cy_r;
            zero_out  <= (result_r == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_out <= 1'b0;
        end else begin
            done_out <= commit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_out <= 1'b0;
        end else if (clear_in) begin
            overrun_out <= 1'b0;
        end else if (lost) begin
            overrun_out <= 1'b1;
        end
    end

endmodule
